simple_add_example_result_checker: RTL and testbench
====================================================

# simple_add_example_result_checker

AXI4-Stream sink that terminates the adder's output stream and checks every 32-bit lane against the value the number generator and adder must have produced: incrementing sequence plus `ctrl_constant`, modulo 2^32. It is the receive-side counterpart of the generator/adder path. It sits on `m_axis_*` of the vector-add kernel in loopback and hardware self-test builds, and reports mismatch counts and completion to control logic.

## Interface
- `C_S_AXIS_TDATA_WIDTH`, 512: stream width in bits; multiple of 32.
- `C_NUMBER_BIT_WIDTH`, 32: lane width; fixed at 32.
- `C_LENGTH_IN_BYTES`, 16384: transfer length. `NBEATS = C_LENGTH_IN_BYTES/(C_S_AXIS_TDATA_WIDTH/8)` (256 at default).
- `aclk`  in  1  sole clock; all logic is on its rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  level; sampled only in IDLE.
- `ctrl_constant`  in  32  expected adder offset; sampled at start.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready.
- `s_axis_tdata`  in  C_S_AXIS_TDATA_WIDTH  result lanes; lane i is bits [32i+31:32i].
- `s_axis_tkeep`  in  C_S_AXIS_TDATA_WIDTH/8  byte enables; must be all ones.
- `s_axis_tlast`  in  1  must be high on beat NBEATS-1 only.
- `ap_done`  out  1  one-cycle completion pulse.
- `error_count`  out  32  lane mismatches plus keep errors; saturates at 0xFFFFFFFF.
- `first_error_beat`  out  32  beat index of first error; 0xFFFFFFFF when none.
- `tlast_error`  out  1  sticky tlast misplacement flag.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE: `s_axis_tready`=0. If `ap_start`=1, then on the next edge:
  - latch `ctrl_constant`;
  - set beat counter to 0 and `expected_base` to 0;
  - clear `error_count` and `tlast_error`;
  - set `first_error_beat` to 0xFFFFFFFF;
  - go to RUN.
- RUN: `s_axis_tready`=1. On each accepted beat n (tvalid&tready), lane i is expected to equal `expected_base + i + const` mod 2^32. After the beat, `expected_base` += `LANES` (wraps mod 2^32) and the beat counter increments.
- Per-beat error weight = number of mismatching lanes, +1 if tkeep is not all ones. This weight is added to `error_count`, saturating. If the weight is nonzero and no earlier error exists, `first_error_beat` is set to n.
- tlast checking sets `tlast_error` on either condition:
  - tlast=1 on beat n<NBEATS-1;
  - tlast=0 on beat NBEATS-1.
- Beat NBEATS-1 is always the final beat regardless of tlast. Acceptance of the final beat moves RUN to FLUSH.
- FLUSH: `s_axis_tready`=0. Wait for the compare pipeline to drain, pulse `ap_done`, then go to IDLE.
- `ap_start` is ignored outside IDLE.
- Results hold in IDLE until the next start.

## Timing
- Reset values:
  - state=IDLE;
  - `s_axis_tready`=0, `ap_done`=0;
  - `error_count`=0;
  - `first_error_beat`=0xFFFFFFFF;
  - `tlast_error`=0.
- `s_axis_tready` is registered from state only, with no combinational path from tvalid. It is 1 from the cycle after start is sampled.
- Compare pipeline: handshake at cycle T; per-lane mismatch vector and tlast/keep flags registered at T+1; counters, `first_error_beat` and `tlast_error` visible at T+2.
- The final beat at T gives `ap_done`=1 during T+2 only, with final counters valid in the same cycle. State is IDLE at T+3.
- Sustains one beat per cycle; `s_axis_tvalid` gaps are allowed with no effect.
- `areset` mid-transfer: all state returns to reset values on the next edge. The in-flight pipeline is discarded and no `ap_done` is issued.
- `ap_start` held high through `ap_done`: a new run begins at T+3, and counters clear at T+4.

## Configuration
- `SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN`
  - Defined: in RUN, a free-running 3-bit counter (reset 0, counts every cycle) forces `s_axis_tready`=0 whenever counter[1:0]==3. This gives a 75% ready duty cycle to exercise adder/FIFO backpressure. Checks and results are unchanged.
  - Undefined: the counter is absent and tready is 1 for the whole of RUN.

## Test plan
- const=5, 256 clean beats, tvalid continuous, tlast on beat 255 -> `error_count`=0, `first_error_beat`=0xFFFFFFFF, `tlast_error`=0, `ap_done` 2 cycles after last handshake.
- Same, but lane 3 of beat 10 = expected XOR 1 and beat 200 lanes 0..1 corrupt -> `error_count`=3, `first_error_beat`=10.
- tlast on beat 100 and also on beat 255 -> `tlast_error`=1, `error_count`=0; no tlast anywhere -> `tlast_error`=1 and `ap_done` still fires.
- const=0xFFFFFFFF: beat 0 lane 0 = 0xFFFFFFFF and lane 1 = 0x00000000 -> no errors (wrap). Beat 1 with tkeep bit 7 = 0 -> `error_count`=1, `first_error_beat`=1.
- Assert `areset` at beat 50, then restart with const=7 -> no `ap_done` from the first run; the second run completes clean with `error_count`=0.
- Macro defined, continuous tvalid -> tready low every 4th cycle, 256 beats accepted in 341±1 cycles, zero errors.

Source files
------------

// File: rtl/simple_add_example_result_checker.sv
// AXI4-Stream sink that checks adder results against sequence + constant.
// Optional: SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN throttles tready.
module simple_add_example_result_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 512,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  input  logic [31:0]                       ctrl_constant,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              ap_done,
  output logic [31:0]                       error_count,
  output logic [31:0]                       first_error_beat,
  output logic                              tlast_error
);

  localparam int LANES = C_S_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
  localparam int KW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int NBEATS = C_LENGTH_IN_BYTES / KW;
  localparam logic [31:0] LAST_BEAT = 32'(NBEATS - 1);
  localparam logic [31:0] LANES32 = 32'(LANES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state_q, state_d;
  logic tready_q, tready_d;
  logic done_q, done_d;
  logic [31:0] const_q, const_d;
  logic [31:0] base_q, base_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] ecnt_q, ecnt_d;
  logic [31:0] feb_q, feb_d;
  logic tlerr_q, tlerr_d;

  logic s1_vld_q, s1_vld_d;
  logic s1_last_q, s1_last_d;
  logic s1_kerr_q, s1_kerr_d;
  logic s1_tlerr_q, s1_tlerr_d;
  logic [31:0] s1_beat_q, s1_beat_d;
  logic [LANES-1:0] s1_mis_q, s1_mis_d;

`ifdef SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN
  logic [2:0] bp_cnt_q, bp_cnt_d;
`endif

  logic hs;
  logic is_last;
  logic [LANES-1:0] mis;
  logic [31:0] weight;
  logic [32:0] sum;

  assign hs = s_axis_tvalid & tready_q;
  assign is_last = (beat_q == LAST_BEAT);

  // Per-lane compare of the incoming beat against the expected sequence
  always_comb begin
    mis = '0;
    for (int i = 0; i < LANES; i++) begin
      mis[i] = s_axis_tdata[C_NUMBER_BIT_WIDTH*i +: C_NUMBER_BIT_WIDTH]
               != (base_q + 32'(i) + const_q);
    end
  end

  // Error weight of the registered beat and saturating accumulation
  always_comb begin
    weight = 32'(s1_kerr_q);
    for (int i = 0; i < LANES; i++) begin
      weight = weight + 32'(s1_mis_q[i]);
    end
    sum = {1'b0, ecnt_q} + {1'b0, weight};
  end

  // Next-state: FSM, stream bookkeeping and the two compare stages
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    const_d   = const_q;
    base_d    = base_q;
    beat_d    = beat_q;
    ecnt_d    = ecnt_q;
    feb_d     = feb_q;
    tlerr_d   = tlerr_q;
    s1_vld_d  = 1'b0;
    s1_mis_d  = mis;
    s1_kerr_d = ~&s_axis_tkeep;
    s1_tlerr_d = s_axis_tlast ^ is_last;
    s1_last_d = is_last;
    s1_beat_d = beat_q;

    if (s1_vld_q) begin
      ecnt_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      if (weight != 32'd0 && feb_q == 32'hFFFF_FFFF) begin
        feb_d = s1_beat_q;
      end
      if (s1_tlerr_q) begin
        tlerr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          const_d = ctrl_constant;
          beat_d  = 32'd0;
          base_d  = 32'd0;
          ecnt_d  = 32'd0;
          tlerr_d = 1'b0;
          feb_d   = 32'hFFFF_FFFF;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          s1_vld_d = 1'b1;
          base_d   = base_q + LANES32;
          beat_d   = beat_q + 32'd1;
          if (is_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (s1_vld_q && s1_last_q) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN
    bp_cnt_d = bp_cnt_q + 3'd1;
    tready_d = (state_d == RUN) && (bp_cnt_d[1:0] != 2'd3);
`else
    tready_d = (state_d == RUN);
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      done_q     <= 1'b0;
      const_q    <= 32'd0;
      base_q     <= 32'd0;
      beat_q     <= 32'd0;
      ecnt_q     <= 32'd0;
      feb_q      <= 32'hFFFF_FFFF;
      tlerr_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_kerr_q  <= 1'b0;
      s1_tlerr_q <= 1'b0;
      s1_beat_q  <= 32'd0;
      s1_mis_q   <= '0;
`ifdef SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN
      bp_cnt_q   <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      done_q     <= done_d;
      const_q    <= const_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      ecnt_q     <= ecnt_d;
      feb_q      <= feb_d;
      tlerr_q    <= tlerr_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_kerr_q  <= s1_kerr_d;
      s1_tlerr_q <= s1_tlerr_d;
      s1_beat_q  <= s1_beat_d;
      s1_mis_q   <= s1_mis_d;
`ifdef SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN
      bp_cnt_q   <= bp_cnt_d;
`endif
    end
  end

  assign s_axis_tready    = tready_q;
  assign ap_done          = done_q;
  assign error_count      = ecnt_q;
  assign first_error_beat = feb_q;
  assign tlast_error      = tlerr_q;

endmodule

// File: tb/tb_simple_add_example_result_checker.sv
// Scoreboard bench for simple_add_example_result_checker.
// Driver pushes expected results; a monitor checks them on ap_done.
module tb_simple_add_example_result_checker;

  localparam int W = 512;
  localparam int LANES = 16;
  localparam int KW = 64;
  localparam int NB = 256;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic ap_start = 1'b0;
  logic [31:0] ctrl_constant = 32'd0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [W-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '1;
  logic s_axis_tlast = 1'b0;
  logic ap_done;
  logic [31:0] error_count;
  logic [31:0] first_error_beat;
  logic tlast_error;

  simple_add_example_result_checker dut (
    .aclk(clk),
    .areset(areset),
    .ap_start(ap_start),
    .ctrl_constant(ctrl_constant),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .ap_done(ap_done),
    .error_count(error_count),
    .first_error_beat(first_error_beat),
    .tlast_error(tlast_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ec;
    logic [31:0] feb;
    logic tl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_cyc_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!areset && ap_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("error_count", error_count, e.ec);
        chk("first_error_beat", first_error_beat, e.feb);
        chk("tlast_error", {31'd0, tlast_error}, {31'd0, e.tl});
        chk("done_cycle", 32'(cyc), 32'(done_cyc_exp));
      end
    end
  end

  function automatic logic [W-1:0] mk(input int t, input logic [31:0] c,
                                      input int n);
    logic [W-1:0] d;
    logic [31:0] v;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      v = 32'(n * LANES + i) + c;
      if (t == 2 && ((n == 10 && i == 3) || (n == 200 && i < 2))) begin
        v = v ^ 32'h1;
      end
      d[32*i +: 32] = v;
    end
    return d;
  endfunction

  task automatic check_reset();
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_done", {31'd0, ap_done}, 32'd0);
    chk("rst_error_count", error_count, 32'd0);
    chk("rst_first_error_beat", first_error_beat, 32'hFFFF_FFFF);
    chk("rst_tlast_error", {31'd0, tlast_error}, 32'd0);
  endtask

  task automatic run(input int t, input logic [31:0] c, input int rst_at,
                     input exp_t e, output int span, output int lat);
    int n;
    int bud;
    int first;
    int last;
    int st;
    logic rdy;
    logic [KW-1:0] k;
    n = 0;
    bud = 0;
    first = -1;
    last = 0;
    if (rst_at < 0) sb.push_back(e);
    @(posedge clk);
    #1;
    ap_start = 1'b1;
    ctrl_constant = c;
    @(posedge clk);
    #1;
    st = cyc;
    ap_start = 1'b0;
    ctrl_constant = 32'hDEAD_BEEF;
    while (n < NB && bud < 2000) begin
      bud++;
      if (n == rst_at) begin
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        break;
      end
      s_axis_tvalid = !(t == 2 && (bud % 7 == 0));
      s_axis_tdata = mk(t, c, n);
      k = '1;
      if (t == 5 && n == 1) k[7] = 1'b0;
      s_axis_tkeep = k;
      if (t == 3) s_axis_tlast = (n == 100 || n == NB - 1);
      else if (t == 4) s_axis_tlast = 1'b0;
      else s_axis_tlast = (n == NB - 1);
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      if (rdy && s_axis_tvalid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
        if (n == NB) done_cyc_exp = last + 1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tkeep = '1;
    if (n < NB && rst_at < 0) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", n, NB);
    end
    bud = 0;
    while (sb.size() != 0 && bud < 20) begin
      @(posedge clk);
      bud++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done");
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    span = last - first + 1;
    lat = first - st;
  endtask

  initial begin
    exp_t e;
    int span;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    areset = 1'b0;

    e = '{ec: 32'd0, feb: 32'hFFFF_FFFF, tl: 1'b0};
    run(1, 32'd5, -1, e, span, lat);
`ifdef SIMPLE_ADD_EXAMPLE_CHECKER_BACKPRESSURE_EN
    checks++;
    if (span < 340 || span > 342) begin
      errors++;
      $display("FAIL bp_span: got %0d expected 341+-1", span);
    end
`else
    chk("span", 32'(span), 32'd256);
    chk("first_beat_latency", 32'(lat), 32'd1);
`endif

    e = '{ec: 32'd3, feb: 32'd10, tl: 1'b0};
    run(2, 32'd5, -1, e, span, lat);

    e = '{ec: 32'd0, feb: 32'hFFFF_FFFF, tl: 1'b1};
    run(3, 32'd5, -1, e, span, lat);

    e = '{ec: 32'd0, feb: 32'hFFFF_FFFF, tl: 1'b1};
    run(4, 32'd5, -1, e, span, lat);

    e = '{ec: 32'd1, feb: 32'd1, tl: 1'b0};
    run(5, 32'hFFFF_FFFF, -1, e, span, lat);

    run(6, 32'd5, 50, e, span, lat);
    check_reset();
    repeat (10) @(posedge clk);
    #1;

    e = '{ec: 32'd0, feb: 32'hFFFF_FFFF, tl: 1'b0};
    run(7, 32'd7, -1, e, span, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
